// File: rtl/csi2_pkg.sv
// -----------------------------------------------------------------------------
// csi2_pkg
// Shared definitions for the CSI-2 transmit packet path:
//   - data-type codes for the short and long packets
//   - the packet builder FSM state encoding
//   - csi2_ecc(): 6-bit Hamming ECC over the 24 packet-header bits
// Optional build macro: CSI2_LINE_SYNC_EN adds the LS/LE states to the enum.
// -----------------------------------------------------------------------------
package csi2_pkg;

    localparam logic [5:0] DT_FS   = 6'h00;
    localparam logic [5:0] DT_FE   = 6'h01;
    localparam logic [5:0] DT_LS   = 6'h02;
    localparam logic [5:0] DT_LE   = 6'h03;
    localparam logic [5:0] DT_RAW8 = 6'h2A;

`ifdef CSI2_LINE_SYNC_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_FS, ST_LS, ST_LH, ST_LPAY, ST_LCRC, ST_LE, ST_FE
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_FS, ST_LH, ST_LPAY, ST_LCRC, ST_FE
    } state_t;
`endif

    // d[0] is DI bit 0, d[23] is WC bit 15. Result is {2'b00, P5..P0}.
    function automatic logic [7:0] csi2_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^
               d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^
               d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
        p[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^
               d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
        p[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^
               d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
        p[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^
               d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
        p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^
               d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
        return {2'b00, p};
    endfunction

endpackage

// File: rtl/csi2_crc16_x4.sv
// -----------------------------------------------------------------------------
// csi2_crc16_x4
// Combinational CSI-2 payload CRC16 step over one 32-bit word (four bytes).
// Polynomial x^16+x^12+x^5+1 processed LSB-first (reflected 0x8408).
// Byte 0 (data[7:0]) is folded first, each byte least significant bit first.
// Ports:
//   crc_in  [15:0] : running CRC before this word
//   data    [31:0] : payload word, byte k on bits [8k+7:8k]
//   crc_out [15:0] : running CRC after this word
// -----------------------------------------------------------------------------
module csi2_crc16_x4 (
    input  logic [15:0] crc_in,
    input  logic [31:0] data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    // Bit order 0..31 is exactly byte 0 LSB first through byte 3 MSB.
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 32; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 16'h8408;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/csi2_pkt_builder.sv
// -----------------------------------------------------------------------------
// csi2_pkt_builder
// Builds one CSI-2 frame per accepted fs_req: FS short packet, LINES long
// packets of WC payload bytes (header + payload + CRC16), FE short packet.
// Output words are 32-bit lane-interleaved (byte k on lane k) with ECC and
// CRC already inserted; the PHY only adds SoT/EoT framing.
// Optional build macro: CSI2_LINE_SYNC_EN wraps each long packet in LS/LE
// short packets whose WC field is the 1-based line number.
// Ports:
//   byteclk, rstn        : byte clock, asynchronous active-low reset
//   fs_req / fs_drop     : frame request in, pulse when request is ignored
//   busy                 : frame in progress (until FE word consumed)
//   i_data/i_valid/i_ready : payload word stream in
//   o_data/o_keep/o_sop/o_eop/o_valid/o_ready : packet word stream out
// -----------------------------------------------------------------------------
module csi2_pkt_builder #(
    parameter logic [15:0] WC      = 16'd4096,
    parameter logic [7:0]  LINES   = 8'd8,
    parameter logic [5:0]  DT_DATA = 6'h2A,
    parameter logic [1:0]  VC      = 2'd0
) (
    input  logic        byteclk,
    input  logic        rstn,
    input  logic        fs_req,
    output logic        fs_drop,
    output logic        busy,
    input  logic [31:0] i_data,
    input  logic        i_valid,
    output logic        i_ready,
    output logic [31:0] o_data,
    output logic [3:0]  o_keep,
    output logic        o_sop,
    output logic        o_eop,
    output logic        o_valid,
    input  logic        o_ready
);
    import csi2_pkg::*;

    localparam logic [13:0] WORDS = WC[15:2];

    state_t      state;
    state_t      state_nx;
    logic [15:0] fno;
    logic [15:0] crc;
    logic [15:0] crc_nx;
    logic [13:0] rem;
    logic [7:0]  line_idx;
    logic        fe_out;     // output register currently holds the FE word

    logic        adv;
    logic        pay_acc;
    logic        last_line;
    logic [15:0] line_num;

    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_sop;
    logic        out_eop;
    logic        out_fe;

    function automatic logic [31:0] pkt_hdr(input logic [5:0] dt, input logic [15:0] wc);
        logic [23:0] h;
        h = {wc, VC, dt};
        return {csi2_ecc(h), h};
    endfunction

    assign adv       = !o_valid || o_ready;
    assign pay_acc   = i_valid && i_ready;
    assign last_line = (line_idx == (LINES - 8'd1));
    assign line_num  = {8'h00, line_idx + 8'd1};
    // busy covers everything from acceptance until the FE word leaves, so a
    // request coinciding with FE consumption is also dropped.
    assign fs_drop   = fs_req && busy;

    csi2_crc16_x4 u_crc (
        .crc_in  (crc),
        .data    (i_data),
        .crc_out (crc_nx)
    );

    // State register
    always_ff @(posedge byteclk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: every emitting state advances only when the output
    // register can take a new word.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (fs_req && !busy) state_nx = ST_FS;
`ifdef CSI2_LINE_SYNC_EN
            ST_FS:   if (adv) state_nx = ST_LS;
            ST_LS:   if (adv) state_nx = ST_LH;
`else
            ST_FS:   if (adv) state_nx = ST_LH;
`endif
            ST_LH:   if (adv) state_nx = ST_LPAY;
            ST_LPAY: if (pay_acc && rem == 14'd1) state_nx = ST_LCRC;
`ifdef CSI2_LINE_SYNC_EN
            ST_LCRC: if (adv) state_nx = ST_LE;
            ST_LE:   if (adv) state_nx = last_line ? ST_FE : ST_LS;
`else
            ST_LCRC: if (adv) state_nx = last_line ? ST_FE : ST_LH;
`endif
            ST_FE:   if (adv) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output logic: candidate word for the output register plus i_ready.
    always_comb begin
        i_ready   = 1'b0;
        out_valid = 1'b0;
        out_data  = 32'h0;
        out_keep  = 4'h0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_fe    = 1'b0;
        case (state)
            ST_FS: begin
                out_valid = 1'b1;
                out_data  = pkt_hdr(DT_FS, fno);
                out_keep  = 4'hF;
                out_sop   = 1'b1;
                out_eop   = 1'b1;
            end
`ifdef CSI2_LINE_SYNC_EN
            ST_LS: begin
                out_valid = 1'b1;
                out_data  = pkt_hdr(DT_LS, line_num);
                out_keep  = 4'hF;
                out_sop   = 1'b1;
                out_eop   = 1'b1;
            end
            ST_LE: begin
                out_valid = 1'b1;
                out_data  = pkt_hdr(DT_LE, line_num);
                out_keep  = 4'hF;
                out_sop   = 1'b1;
                out_eop   = 1'b1;
            end
`endif
            ST_LH: begin
                out_valid = 1'b1;
                out_data  = pkt_hdr(DT_DATA, WC);
                out_keep  = 4'hF;
                out_sop   = 1'b1;
            end
            ST_LPAY: begin
                i_ready = adv && (rem != 14'd0);
                // No input word means a bubble: o_valid drops for a cycle.
                if (i_valid && i_ready) begin
                    out_valid = 1'b1;
                    out_data  = i_data;
                    out_keep  = 4'hF;
                end
            end
            ST_LCRC: begin
                out_valid = 1'b1;
                out_data  = {16'h0000, crc};
                out_keep  = 4'b0011;
                out_eop   = 1'b1;
            end
            ST_FE: begin
                out_valid = 1'b1;
                out_data  = pkt_hdr(DT_FE, fno);
                out_keep  = 4'hF;
                out_sop   = 1'b1;
                out_eop   = 1'b1;
                out_fe    = 1'b1;
            end
            default: ;
        endcase
    end

    // Output register, frame counters and running CRC
    always_ff @(posedge byteclk or negedge rstn) begin
        if (!rstn) begin
            o_valid  <= 1'b0;
            o_data   <= 32'h0;
            o_keep   <= 4'h0;
            o_sop    <= 1'b0;
            o_eop    <= 1'b0;
            fe_out   <= 1'b0;
            busy     <= 1'b0;
            fno      <= 16'd1;
            crc      <= 16'hFFFF;
            rem      <= 14'd0;
            line_idx <= 8'd0;
        end else begin
            if (adv) begin
                o_valid <= out_valid;
                o_data  <= out_data;
                o_keep  <= out_keep;
                o_sop   <= out_sop;
                o_eop   <= out_eop;
                fe_out  <= out_fe;
            end

            if (fs_req && !busy) begin
                busy <= 1'b1;
            end else if (o_valid && o_ready && fe_out) begin
                busy <= 1'b0;
            end

            if (state == ST_LH && adv) begin
                crc <= 16'hFFFF;
                rem <= WORDS;
            end else if (pay_acc) begin
                crc <= crc_nx;
                rem <= rem - 14'd1;
            end

`ifdef CSI2_LINE_SYNC_EN
            if (state == ST_FS) begin
                line_idx <= 8'd0;
            end else if (state == ST_LE && adv) begin
                line_idx <= last_line ? 8'd0 : line_idx + 8'd1;
            end
`else
            if (state == ST_FS) begin
                line_idx <= 8'd0;
            end else if (state == ST_LCRC && adv) begin
                line_idx <= last_line ? 8'd0 : line_idx + 8'd1;
            end
`endif

            // Frame number 0 is reserved: wrap FFFF back to 1.
            if (state == ST_FE && adv) begin
                fno <= (fno == 16'hFFFF) ? 16'd1 : fno + 16'd1;
            end
        end
    end

endmodule
